// File: rtl/fetch_issue_pkg.sv
// Shared types and constants for the fetch-issue slice.
// Holds the fetch FSM encoding, reset PC, pending-request and push-record
// layouts, and helpers for line alignment and the predictor pre-field.
package fetch_issue_pkg;

  localparam logic [31:0] RESET_PC    = 32'h1c00_0000;
  localparam int unsigned FETCH_BYTES = 8;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_DROP = 3'd3,
    S_HALT = 3'd4
  } fetch_state_e;

  // Request in flight: fetch pc plus what the predictor said at issue.
  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic        slot;
    logic [31:0] target;
    logic [1:0]  plv;
  } pend_t;

  // One fetch-buffer push.
  typedef struct packed {
    logic        valid;
    logic        flag;
    logic [31:0] pc;
    logic [63:0] ir;
    logic [63:0] pre;
    logic [1:0]  plv;
    logic        adef;
  } fb_out_t;

  // Pre-field layout: target in [63:32], taken in [0].
  function automatic logic [63:0] make_pre(input logic [31:0] target, input logic taken);
    return {target, 31'b0, taken};
  endfunction

  function automatic logic [31:0] fetch_align(input logic [31:0] pc);
    return pc & ~32'(FETCH_BYTES - 1);
  endfunction

endpackage

// File: rtl/fetch_issue_if.sv
// Icache request/response bus.
// master: fetch side (drives req/addr), slave: icache side (drives handshakes/data).
interface fetch_issue_if;
  logic        icache_req;
  logic [31:0] icache_addr;
  logic        icache_addr_ok;
  logic        icache_data_ok;
  logic [63:0] icache_rdata;

  modport master (output icache_req, icache_addr,
                  input  icache_addr_ok, icache_data_ok, icache_rdata);
  modport slave  (input  icache_req, icache_addr,
                  output icache_addr_ok, icache_data_ok, icache_rdata);
endinterface

// File: rtl/fetch_npc.sv
// Combinational next-pc, dual-issue flag and instruction alignment.
// pc/bp_* : current fetch pc and prediction -> pc_next_c
// pend_*  : request being answered, rdata : line slice -> flag_c, ir_c
module fetch_npc (
  input  logic [31:0] pc,
  input  logic        bp_taken,
  input  logic [31:0] bp_target,
  input  logic        pend_odd,
  input  logic        pend_taken,
  input  logic        pend_slot,
  input  logic [63:0] rdata,
  output logic [31:0] pc_next_c,
  output logic        flag_c,
  output logic [63:0] ir_c
);

  // An upper-word start only has one slot left in the 8-byte line.
  assign pc_next_c = bp_taken ? bp_target : (pc[2] ? pc + 32'd4 : pc + 32'd8);

  // Second slot is dropped when the first one is predicted taken.
  assign flag_c = !pend_odd && !(pend_taken && !pend_slot);
  assign ir_c   = pend_odd ? {32'b0, rdata[63:32]} : rdata;

endmodule

// File: rtl/fetch_issue.sv
// Fetch issue: owns the fetch PC, issues aligned 8-byte icache requests,
// and pushes 1-2 instructions per response into the fetch buffer.
// Ports: clk/rst, flush/flush_pc redirect, stall, fb_full, plv_in,
// ic (icache bus, master), bp_* predictor lookup, fb_* registered push.
module fetch_issue
  import fetch_issue_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic [31:0]   flush_pc,
  input  logic          stall,
  input  logic          fb_full,
  input  logic [1:0]    plv_in,
  fetch_issue_if.master ic,
  output logic [31:0]   bp_pc,
  input  logic          bp_taken,
  input  logic          bp_slot,
  input  logic [31:0]   bp_target,
  output logic          fb_valid,
  output logic          fb_flag,
  output logic [31:0]   fb_pc,
  output logic [63:0]   fb_ir,
  output logic [63:0]   fb_pre,
  output logic [1:0]    fb_plv,
  output logic          fb_adef
);

  fetch_state_e state, state_n;
  logic [31:0]  pc, pc_n;
  pend_t        pend, pend_n;
  fb_out_t      fbo, fbo_n, ld_val;
  logic         req, req_n;
  logic         ld, can_issue;
  logic [31:0]  pc_next_c;
  logic         flag_c;
  logic [63:0]  ir_c;

  fetch_npc u_npc (
    .pc         (pc),
    .bp_taken   (bp_taken),
    .bp_target  (bp_target),
    .pend_odd   (pend.pc[2]),
    .pend_taken (pend.taken),
    .pend_slot  (pend.slot),
    .rdata      (ic.icache_rdata),
    .pc_next_c  (pc_next_c),
    .flag_c     (flag_c),
    .ir_c       (ir_c)
  );

  // Next state, pc, pending record and push-record update.
  always_comb begin
    state_n   = state;
    pc_n      = pc;
    pend_n    = pend;
    ld        = 1'b0;
    ld_val    = '0;
    fbo_n     = fbo;
    // A held push must not be overwritten while the buffer is stalled.
    can_issue = !fbo.valid || !stall;

    case (state)
      S_IDLE: begin
        if (flush) begin
          pc_n = flush_pc;
        end else if (pc[1:0] != 2'b00) begin
          if (can_issue) begin
            ld            = 1'b1;
            ld_val.valid  = 1'b1;
            ld_val.adef   = 1'b1;
            ld_val.pc     = pc;
            ld_val.plv    = plv_in;
            state_n       = S_HALT;
          end
        end else if (!fb_full && can_issue) begin
          state_n = S_REQ;
        end
      end
      S_REQ: begin
        if (ic.icache_addr_ok) begin
          pend_n  = '{pc: pc, taken: bp_taken, slot: bp_slot, target: bp_target, plv: plv_in};
          pc_n    = flush ? flush_pc : pc_next_c;
          state_n = flush ? S_DROP : S_WAIT;
        end else if (flush) begin
          pc_n    = flush_pc;
          state_n = S_IDLE;
        end
      end
      S_WAIT: begin
        if (flush) begin
          pc_n    = flush_pc;
          state_n = ic.icache_data_ok ? S_IDLE : S_DROP;
        end else if (ic.icache_data_ok) begin
          ld           = 1'b1;
          ld_val.valid = 1'b1;
          ld_val.flag  = flag_c;
          ld_val.pc    = pend.pc;
          ld_val.ir    = ir_c;
          ld_val.pre   = make_pre(pend.target, pend.taken);
          ld_val.plv   = pend.plv;
          state_n      = S_IDLE;
        end
      end
      S_DROP: begin
        if (flush) pc_n = flush_pc;
        if (ic.icache_data_ok) state_n = S_IDLE;
      end
      S_HALT: begin
        if (flush) begin
          pc_n    = flush_pc;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase

    if (flush)       fbo_n.valid = 1'b0;
    else if (ld)     fbo_n       = ld_val;
    else if (!stall) fbo_n.valid = 1'b0;

    req_n = (state_n == S_REQ);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      pc    <= RESET_PC;
      pend  <= '0;
      fbo   <= '0;
      req   <= 1'b0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      pend  <= pend_n;
      fbo   <= fbo_n;
      req   <= req_n;
    end
  end

  assign ic.icache_req  = req;
  assign ic.icache_addr = fetch_align(pc);
  assign bp_pc          = pc;

  assign fb_valid = fbo.valid;
  assign fb_flag  = fbo.flag;
  assign fb_pc    = fbo.pc;
  assign fb_ir    = fbo.ir;
  assign fb_pre   = fbo.pre;
  assign fb_plv   = fbo.plv;
  assign fb_adef  = fbo.adef;

endmodule

// File: doc/fetch_issue.md
Name: fetch_issue

Overview:
- Producer side of the fetch buffer: owns the fetch PC and issues aligned 8-byte requests to the icache.
- Consults the branch predictor and pushes 1 or 2 instructions per response into the fetch buffer (pc, 64-bit ir, flag, icache_valid, plv, pre).
- Sits between the PC-redirect logic (flush from backend) and the fetch buffer.
- Honours fetch-buffer almost-full and the global pipeline stall.

Parameters:
RESET_PC, 32'h1c00_0000, fetch PC after reset.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  backend redirect; highest priority after rst
flush_pc  in  32  redirect target
stall  in  1  global stall; fetch buffer ignores pushes while high
fb_full  in  1  fetch buffer almost-full (stall_fetch_buffer)
plv_in  in  2  current privilege level
icache_req  out  1  request valid
icache_addr  out  32  {pc[31:3],3'b000}
icache_addr_ok  in  1  request accepted this cycle
icache_data_ok  in  1  response valid this cycle
icache_rdata  in  64  aligned 8-byte line slice
bp_pc  out  32  current fetch pc, to predictor (combinational lookup)
bp_taken  in  1  predicted taken
bp_slot  in  1  0: taken at pc[31:3]+0, 1: at +4
bp_target  in  32  predicted target
fb_valid  out  1  push valid (icache_valid)
fb_flag  out  1  1: two instructions valid, 0: one
fb_pc  out  32  pc of fb_ir[31:0]
fb_ir  out  64  instructions, older in [31:0]
fb_pre  out  64  {target, 31'b0, taken}
fb_plv  out  2  plv at request issue
fb_adef  out  1  address-error marker

Behaviour:
- FSM states: IDLE, REQ, WAIT, DROP, HALT.
- Reset: state=IDLE; pc=RESET_PC; all fb_* outputs 0; icache_req=0.
- Output register (ovld) drives all fb_* signals; fb_valid=ovld.
  - ovld clears on any cycle with !stall (the buffer consumed it), unless a new load happens in the same cycle.
  - flush clears ovld.
- IDLE:
  - If pc[1:0]!=0: load ovld with fb_adef=1, fb_flag=0, fb_ir=0, fb_pc=pc; go HALT.
  - Else if !fb_full && !flush && (!ovld || !stall): go REQ.
- REQ:
  - icache_req=1 and icache_addr held stable.
  - On addr_ok:
    - Latch bp_taken/bp_slot/bp_target, plv_in and pc into the pending record.
    - pc_next = bp_taken ? bp_target : (pc[2] ? pc+4 : pc+8).
    - Go WAIT.
    - A data_ok in the same cycle as addr_ok is illegal; the icache never produces it.
  - flush without addr_ok: withdraw the request, pc=flush_pc, go IDLE.
  - flush with addr_ok in the same cycle: go DROP.
- WAIT:
  - On data_ok (no flush): load ovld, go IDLE.
    - fb_pc = pending pc.
    - fb_ir = pc[2] ? {32'b0, rdata[63:32]} : rdata.
    - fb_flag = !pc[2] && !(taken && !slot).
    - fb_pre = {target, 31'b0, taken}; fb_plv = pending plv; fb_adef=0.
  - flush without data_ok: go DROP.
  - flush with data_ok in the same cycle: discard the data, go IDLE.
  - In every flush case: pc=flush_pc.
- DROP:
  - Wait for data_ok, discard it, go IDLE.
  - A further flush updates pc only.
- HALT: leave only on flush (pc=flush_pc, go IDLE).
- Invariants:
  - At most one outstanding request.
  - No issue while ovld && stall, so ovld is never overwritten.
  - fb_full is sampled only at issue. An in-flight response always fits, because the buffer asserts full with ≥2 free slots.
- rst mid-transaction: immediate IDLE. A late data_ok from the prior request is not tracked; the icache is reset with the same rst.
- Arithmetic: pc increment is 32-bit wrap-around, no overflow detection.

Decomposition:
- Shared package holds: fetch FSM state encoding, RESET_PC constant, the pre-field layout (target [63:32], taken [0]), and the 8-byte fetch alignment constant.
- One natural sub-module, fetch_npc: a combinational next-pc/flag/ir-align unit that takes pc, bp_* and rdata and returns pc_next, flag and aligned ir.

Test Plan:
- Reset, no prediction, icache answering in 1 cycle → requests at 0x1c000000, then 0x1c000008; pushes fb_pc=0x1c000000, flag=1, then fb_pc=0x1c000008.
- Redirect to 0x1c000104 → icache_addr=0x1c000100; fb_ir={0, rdata[63:32]}, flag=0; next request at 0x1c000108.
- bp_taken=1, bp_slot=0, target 0x1c000400 at pc 0x1c000000 → flag=0, fb_pre[63:32]=0x1c000400, fb_pre[0]=1; next request at 0x1c000400.
- flush(0x1c000800) during WAIT, then data_ok → no fb_valid for the stale data; next request at 0x1c000800. Repeat with flush and data_ok in the same cycle → same result.
- stall high for 5 cycles with a response pending → fb_valid held with stable fields, no new icache_req; after stall drops, fb_valid falls the next cycle and the request resumes.
- flush_pc=0x1c000002 → no icache_req; fb_valid=1, fb_adef=1, fb_pc=0x1c000002; FSM stays in HALT until flush to 0x1c000000, then normal fetch resumes.
